exec_dispatcher: RTL
====================

EXEC_DISPATCHER -- requirements
Module: exec_dispatcher

Interface
REQ-001 SHALL have parameter MAX_DEPENDENCIES, default 256: width of each dependency vector.
REQ-002 SHALL have parameter NUM_WORKERS, default 4: number of execution units (>=2).
REQ-003 SHALL have parameter MAX_BATCH_SIZE, default 8: transactions per batch before forced close.
REQ-004 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 clk  input  1  sole clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 s_axis_tvalid / s_axis_tready  input / output  1 / 1  batch-stream handshake.
REQ-008 s_axis_tdata_owner_programID  input  64  transaction ID.
REQ-009 s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies  input  MAX_DEPENDENCIES each  dependency vectors.
REQ-010 s_axis_tlast  input  1  marks the last transaction of a batch.
REQ-011 w_valid / w_ready  output / input  NUM_WORKERS each  per-worker one-hot dispatch handshake.
REQ-012 w_owner_programID, w_read_dependencies, w_write_dependencies  output  64 / MAX_DEPENDENCIES / MAX_DEPENDENCIES  shared dispatch bus.
REQ-013 w_done  input  NUM_WORKERS  single-cycle completion pulse per worker.
REQ-014 batch_completed  output  1  one-cycle pulse when a batch fully retires.
REQ-015 busy_workers  output  $clog2(NUM_WORKERS+1)  count of busy workers.
REQ-016 dispatched_count, batches_count  output  32 each  wrapping counters.
REQ-017 protocol_error  output  1  sticky flag.

Function
REQ-018 SHALL contain a one-entry hold register; s_axis_tready = hold empty AND state != DRAIN.
REQ-019 SHALL latch data and tlast into the hold register on an s_axis handshake; w_valid asserts no earlier than the next cycle.
REQ-020 While the hold register is full and at least one worker is free, SHALL assert exactly one w_valid bit, chosen round-robin from the free workers starting at rr_ptr.
REQ-021 Once asserted, SHALL keep the granted index and w_* data stable until w_ready of that index is high.
REQ-022 On a dispatch handshake: set busy[grant], empty the hold register, set rr_ptr = (grant+1) mod NUM_WORKERS, increment dispatched_count and the batch counter.
REQ-023 If no worker is free, SHALL drive w_valid all zero and keep holding.
REQ-024 FSM states: IDLE (no batch open), DISPATCH (batch open), DRAIN (last dispatched, waiting on retire).
REQ-025 IDLE->DISPATCH on an s_axis handshake.
REQ-026 DISPATCH->DRAIN on a dispatch handshake of an entry with tlast=1, or when the batch counter reaches MAX_BATCH_SIZE (forced close).
REQ-027 DRAIN->IDLE when all busy bits are clear: pulse batch_completed, increment batches_count, clear the batch counter.
REQ-028 w_done[i] with busy[i]=1 SHALL clear busy[i] in the same edge.
REQ-029 w_done[i] with busy[i]=0 SHALL be ignored and SHALL set protocol_error.
REQ-030 A w_done and a dispatch handshake to a different worker in the same cycle SHALL both take effect; busy_workers reflects the net change.
REQ-031 In DRAIN, if the final w_done arrives the same cycle the state is entered, batch_completed SHALL pulse on the next cycle.
REQ-032 Counters SHALL wrap modulo 2^32 without a flag.

Reset
REQ-033 On rst_n low, SHALL go to IDLE and clear hold, busy, rr_ptr, the batch counter, all counters and protocol_error.
REQ-034 During reset, s_axis_tready=0, w_valid=0 and batch_completed=0; in-flight work is discarded and a mid-batch reset does not pulse batch_completed.
REQ-035 s_axis_tready SHALL rise on the first cycle after reset deasserts.

Structure
REQ-036 FSM state encoding and the worker-index width function SHALL be in the shared scheduler package.
REQ-037 Round-robin free-worker selection SHALL be one sub-module, rr_free_arbiter (mask, pointer -> one-hot grant, any_free).

Verification
REQ-038 Batch of 3 (tlast on the 3rd), all workers ready, done 5 cycles after each dispatch -> grants to workers 0,1,2; batch_completed pulses once after the 3rd done; dispatched_count=3, batches_count=1.
REQ-039 NUM_WORKERS=4, 6 transactions, no w_done -> 4 dispatched, then w_valid=0 and s_axis_tready=0; one w_done[2] -> next grant goes to worker 2.
REQ-040 w_ready held low for 10 cycles -> w_valid index and data stable throughout; dispatch on the cycle w_ready rises.
REQ-041 9 transactions without tlast, MAX_BATCH_SIZE=8 -> DRAIN after the 8th dispatch; 9th held off until batch_completed.
REQ-042 w_done[1] while worker 1 is idle -> protocol_error=1 and stays set; busy_workers unchanged.
REQ-043 rst_n asserted with 2 workers busy in DISPATCH -> all outputs zero, no batch_completed; a fresh batch then completes normally.

Source files
------------

// File: rtl/exec_dispatcher_pkg.sv
// Shared scheduler definitions for the execution dispatcher: FSM encoding and
// the worker-index width helper.
package exec_dispatcher_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPATCH = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    function automatic int widx(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exec_dispatcher_if.sv
// Batch-stream input and worker dispatch bus of the execution dispatcher.
interface exec_dispatcher_if #(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int NUM_WORKERS      = 4
);
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [63:0]                 s_axis_tdata_owner_programID;
    logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies;
    logic                        s_axis_tlast;
    logic [NUM_WORKERS-1:0]      w_valid;
    logic [NUM_WORKERS-1:0]      w_ready;
    logic [63:0]                 w_owner_programID;
    logic [MAX_DEPENDENCIES-1:0] w_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] w_write_dependencies;
    logic [NUM_WORKERS-1:0]      w_done;

    // dispatcher side
    modport slave (
        input  s_axis_tvalid, s_axis_tdata_owner_programID,
               s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
               s_axis_tlast, w_ready, w_done,
        output s_axis_tready, w_valid, w_owner_programID,
               w_read_dependencies, w_write_dependencies
    );

    // producer plus worker pool side
    modport master (
        output s_axis_tvalid, s_axis_tdata_owner_programID,
               s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
               s_axis_tlast, w_ready, w_done,
        input  s_axis_tready, w_valid, w_owner_programID,
               w_read_dependencies, w_write_dependencies
    );
endinterface

// File: rtl/exec_dispatcher_rr_free_arbiter.sv
// Round-robin selection of one free worker, searching upward from ptr_i.
module rr_free_arbiter
    import exec_dispatcher_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       mask_i,
    input  logic [widx(N)-1:0] ptr_i,
    output logic [N-1:0]       grant_o,
    output logic               any_free_o
);
    localparam int IW = widx(N);

    logic [IW-1:0] idx_s;
    logic          found_s;

    // first set mask bit at or after the pointer, wrapping around
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = IW'((int'(ptr_i) + k) % N);
            if (!found_s && mask_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_free_o = |mask_i;
    end

endmodule

// File: rtl/exec_dispatcher.sv
// Batch dispatcher: one-entry hold register feeding a pool of workers with
// round-robin grants, batch open/close tracking and retirement accounting.
module exec_dispatcher
    import exec_dispatcher_pkg::*;
#(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int NUM_WORKERS      = 4,
    parameter int MAX_BATCH_SIZE   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    exec_dispatcher_if.slave                   bus,
    output logic                               batch_completed,
    output logic [$clog2(NUM_WORKERS+1)-1:0]   busy_workers,
    output logic [31:0]                        dispatched_count,
    output logic [31:0]                        batches_count,
    output logic                               protocol_error
);
    localparam int IW = widx(NUM_WORKERS);
    localparam int CW = $clog2(NUM_WORKERS + 1);
    localparam int BW = $clog2(MAX_BATCH_SIZE + 1);

    logic [1:0]                  state_q, state_d;
    logic                        hold_full_q, hold_full_d;
    logic                        hold_last_q;
    logic [63:0]                 hold_id_q;
    logic [MAX_DEPENDENCIES-1:0] hold_rd_q, hold_wr_q;
    logic                        tready_q, tready_d;
    logic [NUM_WORKERS-1:0]      grant_q, grant_d;
    logic [NUM_WORKERS-1:0]      busy_q, busy_d;
    logic [CW-1:0]               busy_cnt_q, busy_cnt_d;
    logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]               batch_cnt_q, batch_cnt_d;
    logic [31:0]                 disp_cnt_q, disp_cnt_d;
    logic [31:0]                 batch_tot_q, batch_tot_d;
    logic                        perr_q, perr_d;
    logic                        done_pulse_q, done_pulse_d;

    logic                        s_hs_s, w_hs_s, arb_any_s;
    logic [NUM_WORKERS-1:0]      arb_grant_s;
    logic [IW-1:0]               grant_idx_s;

    function automatic logic [CW-1:0] popcnt(input logic [NUM_WORKERS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_WORKERS; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    function automatic logic [IW-1:0] onehot_idx(input logic [NUM_WORKERS-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    assign s_hs_s      = bus.s_axis_tvalid & tready_q;
    assign w_hs_s      = |(grant_q & bus.w_ready);
    assign grant_idx_s = onehot_idx(grant_q);

    rr_free_arbiter #(.N(NUM_WORKERS)) u_arb (
        .mask_i     (~busy_q),
        .ptr_i      (rr_ptr_q),
        .grant_o    (arb_grant_s),
        .any_free_o (arb_any_s)
    );

    // next-state for hold, grant, busy tracking, counters and batch FSM
    always_comb begin
        state_d      = state_q;
        hold_full_d  = hold_full_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        batch_cnt_d  = batch_cnt_q;
        disp_cnt_d   = disp_cnt_q;
        batch_tot_d  = batch_tot_q;
        done_pulse_d = 1'b0;
        busy_d       = (busy_q & ~bus.w_done) | (w_hs_s ? grant_q : '0);
        perr_d       = perr_q | (|(bus.w_done & ~busy_q));

        if (w_hs_s) begin
            hold_full_d = 1'b0;
            grant_d     = '0;
            rr_ptr_d    = IW'((int'(grant_idx_s) + 1) % NUM_WORKERS);
            disp_cnt_d  = disp_cnt_q + 32'd1;
            batch_cnt_d = batch_cnt_q + BW'(1);
        end else if (s_hs_s) begin
            hold_full_d = 1'b1;
        end else if ((grant_q == '0) && hold_full_q && arb_any_s) begin
            // grant is locked here until the chosen worker accepts
            grant_d = arb_grant_s;
        end else begin
            grant_d = grant_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_hs_s) state_d = ST_DISPATCH;
                else        state_d = ST_IDLE;
            end
            ST_DISPATCH: begin
                if (w_hs_s && (hold_last_q || (batch_cnt_q == BW'(MAX_BATCH_SIZE - 1))))
                    state_d = ST_DRAIN;
                else
                    state_d = ST_DISPATCH;
            end
            ST_DRAIN: begin
                if (busy_q == '0) begin
                    state_d      = ST_IDLE;
                    done_pulse_d = 1'b1;
                    batch_tot_d  = batch_tot_q + 32'd1;
                    batch_cnt_d  = '0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tready_d   = !hold_full_d && (state_d != ST_DRAIN);
        busy_cnt_d = popcnt(busy_d);
    end

    // state registers; hold payload loads only on an accepted stream beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_full_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            hold_id_q    <= 64'd0;
            hold_rd_q    <= '0;
            hold_wr_q    <= '0;
            tready_q     <= 1'b0;
            grant_q      <= '0;
            busy_q       <= '0;
            busy_cnt_q   <= '0;
            rr_ptr_q     <= '0;
            batch_cnt_q  <= '0;
            disp_cnt_q   <= 32'd0;
            batch_tot_q  <= 32'd0;
            perr_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_full_q  <= hold_full_d;
            tready_q     <= tready_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            busy_cnt_q   <= busy_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            batch_cnt_q  <= batch_cnt_d;
            disp_cnt_q   <= disp_cnt_d;
            batch_tot_q  <= batch_tot_d;
            perr_q       <= perr_d;
            done_pulse_q <= done_pulse_d;
            if (s_hs_s) begin
                hold_last_q <= bus.s_axis_tlast;
                hold_id_q   <= bus.s_axis_tdata_owner_programID;
                hold_rd_q   <= bus.s_axis_tdata_read_dependencies;
                hold_wr_q   <= bus.s_axis_tdata_write_dependencies;
            end else begin
                hold_last_q <= hold_last_q;
                hold_id_q   <= hold_id_q;
                hold_rd_q   <= hold_rd_q;
                hold_wr_q   <= hold_wr_q;
            end
        end
    end

    assign bus.s_axis_tready        = tready_q;
    assign bus.w_valid              = grant_q;
    assign bus.w_owner_programID    = hold_id_q;
    assign bus.w_read_dependencies  = hold_rd_q;
    assign bus.w_write_dependencies = hold_wr_q;
    assign batch_completed          = done_pulse_q;
    assign busy_workers             = busy_cnt_q;
    assign dispatched_count         = disp_cnt_q;
    assign batches_count            = batch_tot_q;
    assign protocol_error           = perr_q;

endmodule
